spi_init_sequencer: RTL and testbench

- Upstream driver for the single-register SPI writer stage.
- Walks a parameter-defined table of (6-bit address, 8-bit value) pairs and presents each pair with an enable handshake.
- Generates the SPI serial clock and active-low chip select the writer and accelerometer share.
- Provides a start/busy/done interface to the top-level controller so the sensor is configured after power-up before sampling begins.

---
 rtl/spi_init_sequencer.sv | 162 ++++++++++++++++
 tb/tb_spi_init_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_init_sequencer.sv
// spi_init_sequencer: walks a table of register writes, framing each with SPI clock, chip select and a writer handshake
module spi_init_sequencer #(
   parameter int                     CLK_DIV    = 4,
   parameter int                     NUM_REGS   = 4,
   parameter logic [NUM_REGS*14-1:0] INIT_TABLE = '0,
   parameter int                     TIMEOUT    = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [3:0] regIndex,
   output logic [5:0] address,
   output logic [7:0] value,
   output logic       writeEnable,
   input  logic       writeComplete,
   output logic       SCLK,
   output logic       CS_n
);
   localparam int DW = $clog2(CLK_DIV);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT - 1);
   localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);
   typedef enum logic [3:0] {
      IDLE, LOAD, CS_SETUP, CLOCKING, CS_HOLD, HANDSHAKE, RELEASE, GAP, DONE
   } state_t;
   state_t        state_q, state_d;
   logic [DW-1:0] div_q, div_d, div_nxt;
   logic [5:0]    edge_q, edge_d;
   logic [TW-1:0] to_q, to_d;
   logic [3:0]    reg_index_q, reg_index_d;
   logic [5:0]    address_q, address_d;
   logic [7:0]    value_q, value_d;
   logic          write_enable_q, write_enable_d;
   logic          sclk_q, sclk_d;
   logic          cs_n_q, cs_n_d;
   logic          error_q, error_d;
   logic          tick;
   logic [13:0]   table_w [16];
   genvar g;
   for (g = 0; g < 16; g++) begin : g_table
      if (g < NUM_REGS) begin : g_entry
         assign table_w[g] = INIT_TABLE[14*g +: 14];
      end else begin : g_pad
         assign table_w[g] = '0;
      end
   end
   assign tick    = div_q == DIV_MAX;
   assign div_nxt = tick ? '0 : div_q + 1'b1;
   // next-state and datapath decisions; counters default to zero so every timed state starts fresh
   always_comb begin
      state_d        = state_q;
      div_d          = '0;
      edge_d         = edge_q;
      to_d           = '0;
      reg_index_d    = reg_index_q;
      address_d      = address_q;
      value_d        = value_q;
      write_enable_d = write_enable_q;
      sclk_d         = sclk_q;
      cs_n_d         = cs_n_q;
      error_d        = error_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               error_d     = 1'b0;
               reg_index_d = '0;
               state_d     = LOAD;
            end
         end
         LOAD: begin
            address_d      = table_w[reg_index_q][13:8];
            value_d        = table_w[reg_index_q][7:0];
            write_enable_d = 1'b1;
            cs_n_d         = 1'b0;
            edge_d         = '0;
            state_d        = CS_SETUP;
         end
         CS_SETUP: begin
            div_d   = div_nxt;
            state_d = tick ? CLOCKING : CS_SETUP;
         end
         CLOCKING: begin
            div_d = div_nxt;
            if (tick) begin
               sclk_d  = ~sclk_q;
               edge_d  = edge_q + 6'd1;
               state_d = (edge_q == 6'd31) ? CS_HOLD : CLOCKING;
            end
         end
         CS_HOLD: begin
            div_d = div_nxt;
            if (tick) begin
               cs_n_d  = 1'b1;
               state_d = HANDSHAKE;
            end
         end
         HANDSHAKE: begin
            if (writeComplete) begin
               write_enable_d = 1'b0;
               state_d        = RELEASE;
            end else if (to_q == TO_MAX) begin
               error_d        = 1'b1;
               write_enable_d = 1'b0;
               state_d        = DONE;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         RELEASE: state_d = writeComplete ? RELEASE : GAP;
         GAP: begin
            div_d = div_nxt;
            if (tick) begin
               state_d     = (reg_index_q == LAST_IDX) ? DONE : LOAD;
               reg_index_d = (reg_index_q == LAST_IDX) ? reg_index_q : reg_index_q + 4'd1;
            end
         end
         DONE: state_d = start ? DONE : IDLE;
         default: state_d = IDLE;
      endcase
   end
   // state and datapath registers; reset drops CS_n high and SCLK low at once, discarding any frame
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         div_q          <= '0;
         edge_q         <= '0;
         to_q           <= '0;
         reg_index_q    <= '0;
         address_q      <= '0;
         value_q        <= '0;
         write_enable_q <= 1'b0;
         sclk_q         <= 1'b0;
         cs_n_q         <= 1'b1;
         error_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         div_q          <= div_d;
         edge_q         <= edge_d;
         to_q           <= to_d;
         reg_index_q    <= reg_index_d;
         address_q      <= address_d;
         value_q        <= value_d;
         write_enable_q <= write_enable_d;
         sclk_q         <= sclk_d;
         cs_n_q         <= cs_n_d;
         error_q        <= error_d;
      end
   end
   assign busy        = (state_q != IDLE) && (state_q != DONE);
   assign done        = state_q == DONE;
   assign error       = error_q;
   assign regIndex    = reg_index_q;
   assign address     = address_q;
   assign value       = value_q;
   assign writeEnable = write_enable_q;
   assign SCLK        = sclk_q;
   assign CS_n        = cs_n_q;
endmodule

// File: tb/tb_spi_init_sequencer.sv
// tb_spi_init_sequencer: table-driven runs with a randomized writer model and a cycle-count reference model
module tb_spi_init_sequencer;
   localparam int CD = 2;
   localparam int NR = 2;
   localparam int TO = 16;
   localparam logic [NR*14-1:0] TABLE = {6'h31, 8'h0B, 6'h2D, 8'h08};

   logic clk = 1'b0, reset = 1'b0, start = 1'b0, writeComplete = 1'b0;
   logic busy, done, error, writeEnable, SCLK, CS_n;
   logic [3:0] regIndex;
   logic [5:0] address;
   logic [7:0] value;

   int n_vec = 0, n_err = 0;
   int min_d = 0, max_d = 0, min_h = 1, max_h = 1;
   int dq[$], hq[$], lq[$], rq[$], gq[$];
   logic [15:0] fq[$];

   typedef struct {
      bit hold;
      int min_d, max_d, min_h, max_h;
      bit exp_err;
      int exp_frames;
   } vec_t;
   vec_t vecs[9];

   spi_init_sequencer #(.CLK_DIV(CD), .NUM_REGS(NR), .INIT_TABLE(TABLE), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .error(error),
      .regIndex(regIndex), .address(address), .value(value), .writeEnable(writeEnable),
      .writeComplete(writeComplete), .SCLK(SCLK), .CS_n(CS_n)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // writer model: answers each CS_n rise after a random delay and holds writeComplete a random time
   logic w_cs_p;
   int w_d, w_h;
   initial begin
      w_cs_p = 1'b1;
      forever begin
         @(negedge clk);
         if (reset && !w_cs_p && CS_n) begin
            w_d = $urandom_range(max_d, min_d);
            w_h = $urandom_range(max_h, min_h);
            dq.push_back(w_d);
            hq.push_back(w_h);
            if (w_d < TO) begin
               repeat (w_d) begin
                  check("we_wait", writeEnable, 1);
                  @(negedge clk);
               end
               writeComplete = 1'b1;
               @(negedge clk);
               check("we_drop", writeEnable, 0);
               repeat (w_h - 1) @(negedge clk);
               writeComplete = 1'b0;
            end
         end
         w_cs_p = CS_n;
      end
   end

   // bus monitor: rebuilds each frame from the SCLK rising edges and measures CS_n low/high spans
   logic m_cs_p, m_sclk_p;
   int m_low, m_rise, m_gap;
   logic [15:0] m_frame, m_word;
   logic [5:0] m_addr;
   logic [7:0] m_val;
   initial begin
      m_cs_p = 1'b1; m_sclk_p = 1'b0; m_low = 0; m_rise = 0; m_gap = 0;
      m_frame = '0; m_word = '0; m_addr = '0; m_val = '0;
      forever begin
         @(negedge clk);
         check("busy_done_excl", busy & done, 0);
         if (CS_n) check("sclk_idle", SCLK, 0);
         if (!reset) begin
            m_low = 0;
            m_rise = 0;
         end else if (m_cs_p && !CS_n) begin
            check("reg_index", regIndex, fq.size());
            check("we_cs", writeEnable, 1);
            if (fq.size() > 0) gq.push_back(m_gap);
            m_addr = address; m_val = value; m_low = 1; m_rise = 0; m_frame = '0;
         end else if (!CS_n) begin
            m_low++;
            check("addr_stable", {address, value}, {m_addr, m_val});
            if (SCLK && !m_sclk_p) begin
               m_word = {2'b00, address, value};
               m_frame = {m_frame[14:0], (m_rise < 16) ? m_word[15 - m_rise] : 1'bx};
               m_rise++;
            end
         end else if (!m_cs_p && CS_n) begin
            fq.push_back(m_frame);
            lq.push_back(m_low);
            rq.push_back(m_rise);
            m_gap = 1;
         end else begin
            m_gap++;
         end
         m_cs_p = CS_n;
         m_sclk_p = SCLK;
      end
   end

   task automatic clear_queues();
      dq.delete(); hq.delete(); lq.delete(); rq.delete(); gq.delete(); fq.delete();
   endtask

   task automatic run_vec(input vec_t v);
      int n, cyc, nfr;
      logic [NR*14-1:0] tbl;
      logic [15:0] exp_f;
      tbl = TABLE;
      clear_queues();
      min_d = v.min_d; max_d = v.max_d; min_h = v.min_h; max_h = v.max_h;
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      start = 1'b1;
      n = 0;
      while (!done && n < 5000) begin
         @(negedge clk);
         n++;
         if (n == 1) check("err_clear", error, 0);
         if (!v.hold && n == 1) start = 1'b0;
         if (!v.hold && n == 40) start = 1'b1;
         if (!v.hold && n == 41) start = 1'b0;
      end
      check("done_reached", n < 5000, 1);
      cyc = 1;
      nfr = 0;
      for (int i = 0; i < NR; i++) begin
         if (i >= dq.size()) break;
         nfr++;
         if (dq[i] >= TO) begin
            cyc += 1 + 34 * CD + TO;
            break;
         end
         cyc += 1 + 34 * CD + dq[i] + 1 + hq[i] + CD;
      end
      check("done_cycles", n, cyc);
      check("error", error, v.exp_err);
      check("we_done", writeEnable, 0);
      check("cs_done", CS_n, 1);
      check("busy_done", busy, 0);
      check("reg_last", regIndex, v.exp_frames - 1);
      check("frames", fq.size(), v.exp_frames);
      for (int i = 0; i < fq.size() && i < NR; i++) begin
         exp_f = {2'b00, tbl[14*i +: 14]};
         check("frame", fq[i], exp_f);
         check("cs_low", lq[i], 34 * CD);
         check("rises", rq[i], 16);
      end
      for (int i = 0; i < gq.size() && i < dq.size(); i++)
         check("gap", gq[i], dq[i] + hq[i] + CD + 2);
      if (v.hold) begin
         repeat (6) begin
            @(negedge clk);
            check("done_hold", done, 1);
         end
      end
      start = 1'b0;
      @(negedge clk);
      check("idle_after", done, 0);
      check("err_sticky", error, v.exp_err);
      repeat (20) @(negedge clk);
      check("no_extra_frame", fq.size(), v.exp_frames);
   endtask

   task automatic reset_test();
      int n, r;
      logic p;
      clear_queues();
      min_d = 0; max_d = 2; min_h = 1; max_h = 3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0; r = 0; p = SCLK;
      while (r < 5 && n < 2000) begin
         @(negedge clk);
         n++;
         if (SCLK && !p) r++;
         p = SCLK;
      end
      check("rise5_reached", r, 5);
      #1 reset = 1'b0;
      #1;
      check("rst_cs", CS_n, 1);
      check("rst_sclk", SCLK, 0);
      check("rst_we", writeEnable, 0);
      check("rst_busy", busy, 0);
      check("rst_idx", regIndex, 0);
      check("rst_addr", {address, value}, 0);
      @(negedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("rst_idle_busy", busy, 0);
      check("rst_idle_done", done, 0);
      repeat (3) @(negedge clk);
      run_vec(vecs[0]);
   endtask

   initial begin
      vecs[0] = '{0, 0,   0,   1, 1, 0, 2};
      vecs[1] = '{0, 0,   15,  1, 6, 0, 2};
      vecs[2] = '{0, 16,  16,  1, 1, 1, 1};
      vecs[3] = '{0, 0,   3,   1, 2, 0, 2};
      vecs[4] = '{1, 0,   7,   1, 6, 0, 2};
      vecs[5] = '{0, 15,  15,  5, 5, 0, 2};
      vecs[6] = '{0, 200, 200, 1, 1, 1, 1};
      vecs[7] = '{1, 0,   15,  1, 6, 0, 2};
      vecs[8] = '{0, 0,   15,  1, 6, 0, 2};
      repeat (3) @(negedge clk);
      check("reset_cs", CS_n, 1);
      check("reset_sclk", SCLK, 0);
      check("reset_flags", {busy, done, error, writeEnable}, 0);
      check("reset_data", {regIndex, address, value}, 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 9; i++) run_vec(vecs[i]);
      reset_test();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
